imem_loader: RTL and testbench

Program loader for the Harvard machine's instruction memory. The CPU only reads instruction memory; this block writes it. It accepts a byte stream over a valid/ready handshake, assembles 22-bit instruction words from three bytes each, and writes them to sequential instruction-memory addresses starting at 0. It then checks a trailing XOR checksum byte. It sits between the host/boot byte source and the write port of the instruction memory, and runs before the CPU is released.

---
 rtl/imem_loader.sv | 145 ++++++++++++++
 tb/tb_imem_loader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory program loader: assembles 22-bit words from a byte stream,
// writes them to sequential addresses from 0, then checks a trailing XOR checksum byte.
module imem_loader #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 22,
    parameter int DEPTH   = 64
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic [7:0]         load_len,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               busy,
    output logic               done,
    output logic [1:0]         err
);
    // state | meaning
    // IDLE  | waiting for start
    // B0    | expecting byte with word bits [21:16]
    // B1    | expecting byte with word bits [15:8]
    // B2    | expecting byte with word bits [7:0]
    // WR    | one-cycle instruction-memory write
    // CSUM  | expecting checksum byte
    // FIN   | done pulse, then back to IDLE
    typedef enum logic [2:0] {S_IDLE, S_B0, S_B1, S_B2, S_WR, S_CSUM, S_FIN} state_t;

    localparam int HI_W = INSTR_W - 8;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          csum_q, csum_d;
    logic [HI_W-1:0]     hi_q, hi_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [INSTR_W-1:0]  wdata_q, wdata_d;
    logic [1:0]          err_q, err_d;
    logic                xfer;

    assign byte_ready = (state_q == S_B0) || (state_q == S_B1) ||
                        (state_q == S_B2) || (state_q == S_CSUM);
    assign xfer       = byte_valid & byte_ready;
    assign imem_we    = (state_q == S_WR);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_FIN);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign err        = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        csum_d  = csum_q;
        hi_d    = hi_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d  = 2'b00;
                    cnt_d  = 8'd0;
                    csum_d = 8'd0;
                    len_d  = load_len;
                    if (load_len > 8'(DEPTH)) begin
                        err_d[1] = 1'b1;
                        state_d  = S_FIN;
                    end else if (load_len == 8'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_B0;
                    end
                end
            end
            S_B0: begin
                if (xfer) begin
                    if (byte_in[7:6] != 2'b00) begin
                        err_d[1] = 1'b1;
                        state_d  = S_FIN;
                    end else begin
                        hi_d[HI_W-1 -: 6] = byte_in[5:0];
                        csum_d            = csum_q ^ byte_in;
                        state_d           = S_B1;
                    end
                end
            end
            S_B1: begin
                if (xfer) begin
                    hi_d[7:0] = byte_in;
                    csum_d    = csum_q ^ byte_in;
                    state_d   = S_B2;
                end
            end
            S_B2: begin
                // Latch the write port here so it holds the last written word afterwards.
                if (xfer) begin
                    wdata_d = {hi_q, byte_in};
                    addr_d  = ADDR_W'(cnt_q);
                    csum_d  = csum_q ^ byte_in;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q + 8'd1 == len_q) state_d = S_CSUM;
                else                       state_d = S_B0;
            end
            S_CSUM: begin
                if (xfer) begin
                    if (byte_in != csum_q) err_d[0] = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            csum_q  <= '0;
            hi_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            csum_q  <= csum_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader; expected writes, checksum and error codes
// come from a word-list model of each load.
module tb_imem_loader;
    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [7:0]  load_len;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [21:0] imem_wdata;
    logic        busy;
    logic        done;
    logic [1:0]  err;

    imem_loader #(.ADDR_W(8), .INSTR_W(22), .DEPTH(64)) dut (
        .CLK(CLK), .RST(RST), .start(start), .load_len(load_len),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    int          wr_addr_q[$];
    logic [21:0] wr_data_q[$];
    int          done_total = 0;

    always @(negedge CLK) begin
        if (imem_we) begin
            wr_addr_q.push_back(int'(imem_addr));
            wr_data_q.push_back(imem_wdata);
        end
        if (done) done_total++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic pulse_start(input logic [7:0] len);
        start    = 1'b1;
        load_len = len;
        @(negedge CLK);
        start    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int  n;
        bit  taken;
        n     = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        taken = 1'b0;
        repeat (n) begin
            byte_valid = 1'b0;
            @(negedge CLK);
        end
        byte_valid = 1'b1;
        byte_in    = b;
        for (int i = 0; i < 200 && !taken; i++) begin
            if (byte_ready) taken = 1'b1;
            @(negedge CLK);
        end
        byte_valid = 1'b0;
        if (!taken) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: byte %h never accepted, byte_ready=%b", b, byte_ready);
        end
    endtask

    task automatic send_word(input logic [21:0] w, input int max_gap);
        send_byte({2'b00, w[21:16]}, max_gap);
        send_byte(w[15:8], max_gap);
        send_byte(w[7:0], max_gap);
    endtask

    function automatic logic [7:0] model_csum(input logic [21:0] ws[$]);
        logic [7:0] c = 8'h00;
        foreach (ws[i]) c = c ^ {2'b00, ws[i][21:16]} ^ ws[i][15:8] ^ ws[i][7:0];
        return c;
    endfunction

    task automatic test_reset();
        RST = 1'b1; start = 1'b0; load_len = 8'd0; byte_in = 8'd0; byte_valid = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({byte_ready, imem_we, imem_addr, imem_wdata, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b we=%b addr=%h wdata=%h done=%b err=%b, want all 0",
                     byte_ready, imem_we, imem_addr, imem_wdata, done, err);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_two_words(input logic [7:0] ck);
        logic [21:0] ws[$];
        logic [1:0]  exp_err;
        int          base, d0;
        ws      = '{22'h3FFFFF, 22'h000102};
        exp_err = (ck != model_csum(ws)) ? 2'b01 : 2'b00;
        base    = wr_addr_q.size();
        d0      = done_total;
        pulse_start(8'd2);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL two_busy_rise: got %b want 1", busy); end
        send_word(ws[0], 0);
        checks++;
        if ({imem_we, byte_ready, imem_addr, imem_wdata} !== {1'b1, 1'b0, 8'd0, ws[0]}) begin
            errors++;
            $display("FAIL two_write_latency: got we=%b ready=%b addr=%h data=%h want 1 0 00 %h",
                     imem_we, byte_ready, imem_addr, imem_wdata, ws[0]);
        end
        send_word(ws[1], 0);
        send_byte(ck, 0);
        checks++;
        if ({done, err} !== {1'b1, exp_err}) begin
            errors++;
            $display("FAIL two_done: got done=%b err=%b want 1 %b", done, err, exp_err);
        end
        @(negedge CLK);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL two_after_done: got busy=%b done=%b want 0 0", busy, done);
        end
        repeat (2) @(negedge CLK);
        checks++;
        if (wr_addr_q.size() - base != 2 || done_total - d0 != 1) begin
            errors++;
            $display("FAIL two_counts: got writes=%0d dones=%0d want 2 1", wr_addr_q.size() - base, done_total - d0);
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (wr_addr_q[base+i] != i || wr_data_q[base+i] !== ws[i]) begin
                    errors++;
                    $display("FAIL two_write%0d: got %0d:%h want %0d:%h", i, wr_addr_q[base+i], wr_data_q[base+i], i, ws[i]);
                end
            end
        end
        checks++;
        if (err !== exp_err) begin errors++; $display("FAIL two_err_hold: got %b want %b", err, exp_err); end
    endtask

    task automatic test_format_err();
        int base;
        base = wr_addr_q.size();
        pulse_start(8'd1);
        send_byte(8'h40, 0);
        checks++;
        if ({done, err, imem_we} !== {1'b1, 2'b10, 1'b0}) begin
            errors++;
            $display("FAIL fmt_done: got done=%b err=%b we=%b want 1 10 0", done, err, imem_we);
        end
        repeat (2) @(negedge CLK);
        checks++;
        if (wr_addr_q.size() != base || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL fmt_no_write: got writes=%0d ready=%b want 0 0", wr_addr_q.size() - base, byte_ready);
        end
    endtask

    task automatic test_too_long();
        int base, done_at;
        bit saw_ready;
        base = wr_addr_q.size(); done_at = -1; saw_ready = 1'b0;
        pulse_start(8'd65);
        for (int i = 0; i < 4; i++) begin
            if (byte_ready) saw_ready = 1'b1;
            if (done && done_at < 0) done_at = i;
            @(negedge CLK);
        end
        checks++;
        if (done_at < 0 || done_at > 1 || saw_ready || err !== 2'b10 || wr_addr_q.size() != base) begin
            errors++;
            $display("FAIL too_long: got done_at=%0d ready_seen=%b err=%b writes=%0d want <=1 0 10 0",
                     done_at, saw_ready, err, wr_addr_q.size() - base);
        end
    endtask

    task automatic test_zero_len();
        int base;
        base = wr_addr_q.size();
        pulse_start(8'd0);
        send_byte(8'h00, 0);
        checks++;
        if ({done, err} !== {1'b1, 2'b00}) begin
            errors++;
            $display("FAIL zero_len: got done=%b err=%b want 1 00", done, err);
        end
        repeat (2) @(negedge CLK);
        checks++;
        if (wr_addr_q.size() != base) begin
            errors++;
            $display("FAIL zero_len_writes: got %0d want 0", wr_addr_q.size() - base);
        end
    endtask

    task automatic test_random_full();
        logic [21:0] ws[$];
        int base, d0;
        for (int i = 0; i < 64; i++) ws.push_back(22'($urandom));
        base = wr_addr_q.size();
        d0   = done_total;
        pulse_start(8'd64);
        for (int i = 0; i < 64; i++) begin
            if (i == 20) pulse_start(8'd70);
            send_word(ws[i], 2);
        end
        send_byte(model_csum(ws), 2);
        checks++;
        if ({done, err} !== {1'b1, 2'b00}) begin
            errors++;
            $display("FAIL full_done: got done=%b err=%b want 1 00", done, err);
        end
        repeat (3) @(negedge CLK);
        checks++;
        if (wr_addr_q.size() - base != 64 || done_total - d0 != 1) begin
            errors++;
            $display("FAIL full_counts: got writes=%0d dones=%0d want 64 1", wr_addr_q.size() - base, done_total - d0);
        end else begin
            for (int i = 0; i < 64; i++) begin
                checks++;
                if (wr_addr_q[base+i] != i || wr_data_q[base+i] !== ws[i]) begin
                    errors++;
                    $display("FAIL full_write%0d: got %0d:%h want %0d:%h", i, wr_addr_q[base+i], wr_data_q[base+i], i, ws[i]);
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        logic [21:0] ws[$];
        logic [21:0] fresh[$];
        int base, d0;
        bit hit3;
        for (int i = 0; i < 5; i++) ws.push_back(22'($urandom));
        base = wr_addr_q.size();
        d0   = done_total;
        pulse_start(8'd5);
        for (int i = 0; i < 3; i++) send_word(ws[i], 1);
        send_byte({2'b00, ws[3][21:16]}, 0);
        send_byte(ws[3][15:8], 0);
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if ({byte_ready, imem_we, imem_addr, imem_wdata, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got ready=%b we=%b addr=%h wdata=%h busy=%b done=%b err=%b want all 0",
                     byte_ready, imem_we, imem_addr, imem_wdata, busy, done, err);
        end
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        hit3 = 1'b0;
        for (int i = base; i < wr_addr_q.size(); i++) if (wr_addr_q[i] == 3) hit3 = 1'b1;
        checks++;
        if (wr_addr_q.size() - base != 3 || hit3 || done_total != d0) begin
            errors++;
            $display("FAIL rst_mid_writes: got writes=%0d addr3=%b dones=%0d want 3 0 0",
                     wr_addr_q.size() - base, hit3, done_total - d0);
        end
        for (int i = 0; i < 3; i++) fresh.push_back(22'($urandom));
        base = wr_addr_q.size();
        pulse_start(8'd3);
        for (int i = 0; i < 3; i++) send_word(fresh[i], 0);
        send_byte(model_csum(fresh), 0);
        checks++;
        if ({done, err} !== {1'b1, 2'b00}) begin
            errors++;
            $display("FAIL rst_fresh_done: got done=%b err=%b want 1 00", done, err);
        end
        repeat (2) @(negedge CLK);
        checks++;
        if (wr_addr_q.size() - base != 3) begin
            errors++;
            $display("FAIL rst_fresh_count: got %0d want 3", wr_addr_q.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_addr_q[base+i] != i || wr_data_q[base+i] !== fresh[i]) begin
                    errors++;
                    $display("FAIL rst_fresh_write%0d: got %0d:%h want %0d:%h", i, wr_addr_q[base+i], wr_data_q[base+i], i, fresh[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_words(8'h3C);
        test_two_words(8'h3D);
        test_format_err();
        test_too_long();
        test_zero_len();
        test_random_full();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
